// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: load-use bubbles, branch squash,
// memory-wait freeze with timeout watchdog, and saturating stall/flush counters.
module pipe_hazard_ctrl #(
    parameter int CNT_W       = 16,
    parameter int MEM_TIMEOUT = 64,
    parameter int TO_W        = 7
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic [4:0]       i_id_rs1_num,
    input  logic [4:0]       i_id_rs2_num,
    input  logic             i_id_uses_rs1,
    input  logic             i_id_uses_rs2,
    input  logic [4:0]       i_ex_rd_num,
    input  logic             i_ex_is_load,
    input  logic             i_ex_branch_taken,
    input  logic             i_mem_req,
    input  logic             i_mem_ready,
    output logic             pc_en,
    output logic             if_id_en,
    output logic             if_id_flush,
    output logic             id_ex_en,
    output logic             id_ex_flush,
    output logic             ex_mem_en,
    output logic             ex_mem_flush,
    output logic             mem_wb_en,
    output logic             mem_wb_flush,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt,
    output logic             mem_err
);

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_MEM_WAIT = 2'd1,
        ST_ERR      = 2'd2
    } state_t;

    // Control vector order: pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_flush,
    // ex_mem_en, ex_mem_flush, mem_wb_en, mem_wb_flush
    localparam logic [8:0] CTL_RUN    = 9'b110101010;
    localparam logic [8:0] CTL_BRANCH = 9'b111111010;
    localparam logic [8:0] CTL_LUSE   = 9'b000111010;
    localparam logic [8:0] CTL_FREEZE = 9'b000000011;
    localparam logic [8:0] CTL_HALT   = 9'b000000000;
    localparam logic [8:0] CTL_RST    = 9'b001010101;

    localparam logic [TO_W-1:0]  TO_ZERO = {TO_W{1'b0}};
    localparam logic [TO_W-1:0]  TO_ONE  = {{(TO_W-1){1'b0}}, 1'b1};
    localparam logic [TO_W-1:0]  TO_LAST = TO_W'(MEM_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

    state_t            state_r;
    state_t            state_nxt_s;
    logic [TO_W-1:0]   wait_cnt_r;
    logic [TO_W-1:0]   wait_nxt_s;
    logic [CNT_W-1:0]  stall_cnt_r;
    logic [CNT_W-1:0]  flush_cnt_r;
    logic              mem_err_r;
    logic              busy_s;
    logic              luse_s;
    logic              stall_inc_s;
    logic              flush_inc_s;
    logic [8:0]        res_ctl_s;
    logic              res_stall_s;
    logic              res_flush_s;
    logic [8:0]        ctl_s;
    logic [8:0]        ctl_out_s;

    function automatic logic src_match(input logic uses, input logic [4:0] src,
                                       input logic [4:0] rd);
        return uses & (src == rd);
    endfunction

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v, input logic inc);
        if (inc && (v != CNT_MAX)) begin
            return v + CNT_ONE;
        end else begin
            return v;
        end
    endfunction

    assign busy_s = i_mem_req & ~i_mem_ready;
    assign luse_s = i_ex_is_load & (i_ex_rd_num != 5'd0) &
                    (src_match(i_id_uses_rs1, i_id_rs1_num, i_ex_rd_num) |
                     src_match(i_id_uses_rs2, i_id_rs2_num, i_ex_rd_num));

    // Hazard resolution when the pipe is free to move: branch beats load-use
    always_comb begin
        res_ctl_s   = CTL_RUN;
        res_stall_s = 1'b0;
        res_flush_s = 1'b0;
        if (i_ex_branch_taken) begin
            res_ctl_s   = CTL_BRANCH;
            res_flush_s = 1'b1;
        end else if (luse_s) begin
            res_ctl_s   = CTL_LUSE;
            res_stall_s = 1'b1;
        end else begin
            res_ctl_s   = CTL_RUN;
        end
    end

    // Next-state, wait counter and control vector
    always_comb begin
        ctl_s       = CTL_RUN;
        state_nxt_s = state_r;
        wait_nxt_s  = wait_cnt_r;
        stall_inc_s = 1'b0;
        flush_inc_s = 1'b0;
        case (state_r)
            ST_RUN: begin
                if (busy_s) begin
                    ctl_s       = CTL_FREEZE;
                    stall_inc_s = 1'b1;
                    wait_nxt_s  = TO_ONE;
                    state_nxt_s = (MEM_TIMEOUT == 1) ? ST_ERR : ST_MEM_WAIT;
                end else begin
                    ctl_s       = res_ctl_s;
                    stall_inc_s = res_stall_s;
                    flush_inc_s = res_flush_s;
                end
            end
            ST_MEM_WAIT: begin
                if (!i_mem_ready) begin
                    ctl_s       = CTL_FREEZE;
                    stall_inc_s = 1'b1;
                    wait_nxt_s  = wait_cnt_r + TO_ONE;
                    if (wait_cnt_r == TO_LAST) begin
                        state_nxt_s = ST_ERR;
                    end else begin
                        state_nxt_s = ST_MEM_WAIT;
                    end
                end else begin
                    ctl_s       = res_ctl_s;
                    stall_inc_s = res_stall_s;
                    flush_inc_s = res_flush_s;
                    wait_nxt_s  = TO_ZERO;
                    state_nxt_s = ST_RUN;
                end
            end
            ST_ERR: begin
                ctl_s       = CTL_HALT;
                state_nxt_s = ST_ERR;
            end
            default: begin
                ctl_s       = CTL_HALT;
                wait_nxt_s  = TO_ZERO;
                state_nxt_s = ST_RUN;
            end
        endcase
    end

    // Reset forces bubbles into every stage for as long as it is held
    assign ctl_out_s = i_rst ? ctl_s : CTL_RST;

    assign {pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_flush,
            ex_mem_en, ex_mem_flush, mem_wb_en, mem_wb_flush} = ctl_out_s;

    // State, wait counter, performance counters and sticky error flag
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            state_r     <= ST_RUN;
            wait_cnt_r  <= TO_ZERO;
            stall_cnt_r <= CNT_ZERO;
            flush_cnt_r <= CNT_ZERO;
            mem_err_r   <= 1'b0;
        end else begin
            state_r     <= state_nxt_s;
            wait_cnt_r  <= wait_nxt_s;
            stall_cnt_r <= sat_inc(stall_cnt_r, stall_inc_s);
            flush_cnt_r <= sat_inc(flush_cnt_r, flush_inc_s);
            mem_err_r   <= mem_err_r | (state_nxt_s == ST_ERR);
        end
    end

    assign stall_cnt = stall_cnt_r;
    assign flush_cnt = flush_cnt_r;
    assign mem_err   = mem_err_r;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Self-checking bench for pipe_hazard_ctrl: directed scenarios then random
// traffic, compared cycle by cycle against a behavioural model of the rules.
module tb_pipe_hazard_ctrl;

    localparam int CW   = 4;
    localparam int TMO  = 4;
    localparam int TW   = 3;
    localparam int CMAX = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          rst;
    logic [4:0]    rs1, rs2, rd;
    logic          u1, u2, ld, br, req, rdy;
    logic          pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_flush;
    logic          ex_mem_en, ex_mem_flush, mem_wb_en, mem_wb_flush;
    logic [CW-1:0] stall_cnt, flush_cnt;
    logic          mem_err;
    logic [8:0]    obs_ctl;

    int errors = 0;
    int checks = 0;

    // Model: mode 0 = running, 1 = waiting on memory, 2 = halted on timeout
    int m_mode, m_waited, m_stall, m_flush;
    bit m_err;

    always #5 clk = ~clk;

    pipe_hazard_ctrl #(.CNT_W(CW), .MEM_TIMEOUT(TMO), .TO_W(TW)) dut (
        .i_clk(clk), .i_rst(rst),
        .i_id_rs1_num(rs1), .i_id_rs2_num(rs2),
        .i_id_uses_rs1(u1), .i_id_uses_rs2(u2),
        .i_ex_rd_num(rd), .i_ex_is_load(ld),
        .i_ex_branch_taken(br), .i_mem_req(req), .i_mem_ready(rdy),
        .pc_en(pc_en), .if_id_en(if_id_en), .if_id_flush(if_id_flush),
        .id_ex_en(id_ex_en), .id_ex_flush(id_ex_flush),
        .ex_mem_en(ex_mem_en), .ex_mem_flush(ex_mem_flush),
        .mem_wb_en(mem_wb_en), .mem_wb_flush(mem_wb_flush),
        .stall_cnt(stall_cnt), .flush_cnt(flush_cnt), .mem_err(mem_err)
    );

    assign obs_ctl = {pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_flush,
                      ex_mem_en, ex_mem_flush, mem_wb_en, mem_wb_flush};

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock cycle: drive, check against the model, advance the model
    task automatic step(input logic r, input logic [4:0] a1, input logic [4:0] a2,
                        input logic b1, input logic b2, input logic [4:0] d,
                        input logic l, input logic b, input logic q, input logic y);
        logic [8:0] exp;
        bit busy, luse;
        int n_mode, n_waited, n_stall, n_flush;
        bit n_err;
        rst = r; rs1 = a1; rs2 = a2; u1 = b1; u2 = b2; rd = d;
        ld = l; br = b; req = q; rdy = y;
        #1;
        busy = q && !y;
        luse = l && (d != 5'd0) && ((b1 && a1 == d) || (b2 && a2 == d));
        if (!r) begin
            m_mode = 0; m_waited = 0; m_stall = 0; m_flush = 0; m_err = 1'b0;
        end
        n_mode = m_mode; n_waited = m_waited; n_stall = m_stall;
        n_flush = m_flush; n_err = m_err;
        if (!r) begin
            exp = 9'b001010101;
        end else if (m_mode == 2) begin
            exp = 9'b000000000;
        end else if ((m_mode == 0 && busy) || (m_mode == 1 && !y)) begin
            exp = 9'b000000011;
            n_stall  = (m_stall < CMAX) ? m_stall + 1 : CMAX;
            n_waited = m_waited + 1;
            n_mode   = (n_waited >= TMO) ? 2 : 1;
            if (n_mode == 2) n_err = 1'b1;
        end else begin
            n_mode = 0; n_waited = 0;
            if (b) begin
                exp = 9'b111111010;
                n_flush = (m_flush < CMAX) ? m_flush + 1 : CMAX;
            end else if (luse) begin
                exp = 9'b000111010;
                n_stall = (m_stall < CMAX) ? m_stall + 1 : CMAX;
            end else begin
                exp = 9'b110101010;
            end
        end
        check("ctl", 32'(obs_ctl), 32'(exp));
        check("stall_cnt", 32'(stall_cnt), 32'(m_stall));
        check("flush_cnt", 32'(flush_cnt), 32'(m_flush));
        check("mem_err", 32'(mem_err), 32'(m_err));
        @(posedge clk);
        m_mode = n_mode; m_waited = n_waited; m_stall = n_stall;
        m_flush = n_flush; m_err = n_err;
        @(negedge clk);
    endtask

    task automatic idle();
        step(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic do_reset();
        step(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic mem(input logic b, input logic y);
        step(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, b, 1'b1, y);
    endtask

    initial begin
        rst = 1'b0; rs1 = 5'd0; rs2 = 5'd0; u1 = 1'b0; u2 = 1'b0; rd = 5'd0;
        ld = 1'b0; br = 1'b0; req = 1'b0; rdy = 1'b0;
        m_mode = 0; m_waited = 0; m_stall = 0; m_flush = 0; m_err = 1'b0;
        @(negedge clk);

        // Reset with random inputs, then release to idle
        for (int i = 0; i < 3; i++)
            step(1'b0, 5'($urandom), 5'($urandom), 1'($urandom), 1'($urandom),
                 5'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
        idle();

        // Load-use on rs2, then x0 destination never stalls
        step(1'b1, 5'd3, 5'd5, 1'b0, 1'b1, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0);
        idle();
        check("luse_stall_total", 32'(stall_cnt), 32'd1);
        step(1'b1, 5'd0, 5'd0, 1'b1, 1'b1, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0);

        // Branch together with a load-use match
        do_reset();
        step(1'b1, 5'd7, 5'd1, 1'b1, 1'b0, 5'd7, 1'b1, 1'b1, 1'b0, 1'b0);
        idle();
        check("branch_luse_flush", 32'(flush_cnt), 32'd1);
        check("branch_luse_stall", 32'(stall_cnt), 32'd0);

        // Three-cycle memory wait
        do_reset();
        for (int i = 0; i < 3; i++) mem(1'b0, 1'b0);
        mem(1'b0, 1'b1);
        check("mem_wait_stalls", 32'(stall_cnt), 32'd3);
        idle();

        // Branch held through a two-cycle wait
        do_reset();
        for (int i = 0; i < 2; i++) mem(1'b1, 1'b0);
        mem(1'b1, 1'b1);
        check("wait_branch_flush", 32'(flush_cnt), 32'd1);
        idle();

        // Timeout into the error state, then reset out of it
        do_reset();
        for (int i = 0; i < TMO + 2; i++) mem(1'b0, 1'b0);
        check("timeout_err", 32'(mem_err), 32'd1);
        do_reset();
        idle();
        check("err_cleared", 32'(mem_err), 32'd0);

        // Flush counter saturation
        for (int i = 0; i < CMAX + 3; i++)
            step(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0);
        check("flush_saturated", 32'(flush_cnt), 32'(CMAX));

        // Random traffic with occasional resets
        do_reset();
        for (int i = 0; i < 400; i++)
            step(1'($urandom_range(0, 39) != 0),
                 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                 1'($urandom), 1'($urandom), 5'($urandom_range(0, 3)),
                 1'($urandom), 1'($urandom_range(0, 3) == 0),
                 1'($urandom), 1'($urandom_range(0, 2) != 0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
